// File: rtl/n64_rx_bit_decoder.sv
// N64 controller receive front end: times low pulses on the data line, decodes bits, frames a response.
// Optional macro N64_RX_SYNC_EN adds a 2-flop input synchroniser ahead of edge detection.
module n64_rx_bit_decoder #(
    parameter int CLK_PER_US = 12,
    parameter int BIT_COUNT  = 32,
    parameter int TIMEOUT_US = 64
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 Data_In,
    input  logic                 Enable,
    input  logic                 Disable,
    output logic [BIT_COUNT-1:0] Data_Out,
    output logic                 Data_Valid,
    output logic                 Busy,
    output logic                 Error
);

    localparam int TIMEOUT_CYC = TIMEOUT_US * CLK_PER_US;
    localparam int CNT_W       = $clog2(TIMEOUT_CYC + 1);
    localparam int IDX_W       = $clog2(BIT_COUNT + 1);

    // cnt restarts at 0 the cycle after an edge, so it trails the width seen on ln:
    // at a rise, low width = cnt+1; while still low/high, width so far = cnt+2.
    localparam logic [CNT_W-1:0] ONE_MAX    = CNT_W'(2 * CLK_PER_US - 1);
    localparam logic [CNT_W-1:0] LOW_LIMIT  = CNT_W'(4 * CLK_PER_US - 1);
    localparam logic [CNT_W-1:0] HIGH_LIMIT = CNT_W'(4 * CLK_PER_US - 2);
    localparam logic [CNT_W-1:0] ARM_LIMIT  = CNT_W'(TIMEOUT_CYC);
    localparam logic [IDX_W-1:0] STOP_IDX   = IDX_W'(BIT_COUNT);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FALL,
        MEAS_LOW,
        MEAS_HIGH,
        DONE,
        ERROR
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 ln;
    logic                 ln_p1;
    logic                 fall;
    logic                 rise;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [IDX_W-1:0]     bit_idx;
    logic [BIT_COUNT-1:0] shreg;
    logic                 bit_one;
    logic                 at_stop;
    logic                 shift_en;
    logic                 arm;
    logic                 done_fire;
    logic                 err_fire;

`ifdef N64_RX_SYNC_EN
    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= Data_In;
            sync_p1 <= sync_p0;
        end
    end

    assign ln = sync_p1;
`else
    assign ln = Data_In;
`endif

    assign fall    = ln_p1 & ~ln;
    assign rise    = ~ln_p1 & ln;
    assign bit_one = (cnt <= ONE_MAX);
    assign at_stop = (bit_idx == STOP_IDX);
    assign Busy    = (state != IDLE);

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        case (state)
            IDLE: begin
                if (Enable && !Disable)
                    state_nxt = WAIT_FALL;
            end
            WAIT_FALL: begin
                if (fall)
                    state_nxt = MEAS_LOW;
                else if (cnt == ARM_LIMIT)
                    state_nxt = ERROR;
            end
            MEAS_LOW: begin
                if (rise) begin
                    if (!at_stop) begin
                        shift_en  = 1'b1;
                        state_nxt = MEAS_HIGH;
                    end else if (bit_one) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = ERROR;
                    end
                end else if (cnt == LOW_LIMIT) begin
                    state_nxt = ERROR;
                end
            end
            MEAS_HIGH: begin
                if (fall)
                    state_nxt = MEAS_LOW;
                else if (cnt == HIGH_LIMIT)
                    state_nxt = ERROR;
            end
            DONE:    state_nxt = IDLE;
            ERROR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Abort overrides everything, including the DONE/ERROR reporting cycle.
        if (state != IDLE && Disable) begin
            state_nxt = IDLE;
            shift_en  = 1'b0;
        end
    end

    always_comb begin
        cnt_nxt = cnt + CNT_W'(1);
        if (state == IDLE || state_nxt != state || fall || rise)
            cnt_nxt = '0;
    end

    assign arm       = (state == IDLE) && (state_nxt == WAIT_FALL);
    assign done_fire = (state == DONE) && !Disable;
    assign err_fire  = (state == ERROR) && !Disable;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            ln_p1      <= 1'b1;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            Data_Out   <= '0;
            Data_Valid <= 1'b0;
            Error      <= 1'b0;
        end else begin
            state      <= state_nxt;
            ln_p1      <= ln;
            cnt        <= cnt_nxt;
            Data_Valid <= done_fire;
            if (arm) begin
                Error   <= 1'b0;
                bit_idx <= '0;
                shreg   <= '0;
            end
            if (shift_en) begin
                shreg   <= (shreg << 1) | BIT_COUNT'(bit_one);
                bit_idx <= bit_idx + IDX_W'(1);
            end
            if (done_fire)
                Data_Out <= shreg;
            if (err_fire)
                Error <= 1'b1;
        end
    end

endmodule
